// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types, memory FSM states and funct3 constants
package pipeline_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RV} mem_state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] RESULT_LOAD = 2'b01;
   typedef struct packed {
      logic        reg_write;
      logic [1:0]  result_src;
      logic        mem_write;
      logic [2:0]  funct3;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] imm_ext;
      logic [31:0] pc_plus4;
      logic [4:0]  rd;
   } exmem_t;
   typedef struct packed {
      logic        reg_write;
      logic [1:0]  result_src;
      logic [31:0] alu_result;
      logic [31:0] load_data;
      logic [31:0] imm_ext;
      logic [31:0] pc_plus4;
      logic [4:0]  rd;
   } memwb_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane/byte-enable generation, load extraction and access legality
module lsu_align
   import pipeline_pkg::*;
(
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        bad
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        legal, mis;
   assign byte_sel = rdata[{offset, 3'b000} +: 8];
   assign half_sel = rdata[{offset[1], 4'b0000} +: 16];
   // lane selection follows access size so unsigned loads enable the same lanes
   assign be = funct3[1:0] == 2'b00 ? 4'b0001 << offset
             : funct3[1:0] == 2'b01 ? 4'b0011 << {offset[1], 1'b0} : 4'b1111;
   assign wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}}
                : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
   assign load_data = funct3 == F3_B  ? {{24{byte_sel[7]}}, byte_sel}
                    : funct3 == F3_H  ? {{16{half_sel[15]}}, half_sel}
                    : funct3 == F3_BU ? {24'b0, byte_sel}
                    : funct3 == F3_HU ? {16'b0, half_sel} : rdata;
   assign legal = is_load ? funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}
                          : funct3 inside {F3_B, F3_H, F3_W};
   assign mis = (funct3[1:0] == 2'b01 && offset[0]) || (funct3[1:0] == 2'b10 && offset != 2'b00);
   assign bad = (is_load | is_store) & (~legal | mis);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage with req/gnt/rvalid bus FSM, timeout and MEM/WB register
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  exmem_t      ex_i,
   input  logic        ex_valid_i,
   output logic        stall_o,
   output memwb_t      wb_o,
   output logic        wb_valid_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        misalign_o,
   output logic        bus_err_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   mem_state_t       state, next;
   logic [CW-1:0]    cnt;
   logic             is_store, is_load, mem_op, bad, timeout, ok_done, abort, retire, fault;
   logic [31:0]      load_data;
   memwb_t           nxt_wb;
   assign is_store = ex_valid_i & ex_i.mem_write;
   assign is_load  = ex_valid_i & ~ex_i.mem_write & (ex_i.result_src == RESULT_LOAD);
   assign mem_op   = is_store | is_load;
   lsu_align u_align (
      .is_load   (is_load),
      .is_store  (is_store),
      .funct3    (ex_i.funct3),
      .offset    (ex_i.alu_result[1:0]),
      .store_data(ex_i.write_data),
      .rdata     (dmem_rdata_i),
      .be        (dmem_be_o),
      .wdata     (dmem_wdata_o),
      .load_data (load_data),
      .bad       (bad)
   );
   assign timeout = (state != IDLE) && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign ok_done = state == IDLE     ? ex_valid_i & (~mem_op | bad | (is_store & dmem_gnt_i))
                  : state == WAIT_GNT ? is_store & dmem_gnt_i : dmem_rvalid_i;
   // a grant or data arriving on the last allowed cycle still wins over the timeout
   assign abort   = timeout & (state == WAIT_GNT ? ~dmem_gnt_i : ~dmem_rvalid_i);
   assign retire  = ok_done | abort;
   assign fault   = ((state == IDLE) & bad) | abort;
   assign stall_o = mem_op & ~retire;
   assign dmem_req_o  = rst_n & (((state == IDLE) & mem_op & ~bad) | (state == WAIT_GNT));
   assign dmem_we_o   = ex_i.mem_write;
   assign dmem_addr_o = {ex_i.alu_result[31:2], 2'b00};
   assign next = retire ? IDLE
               : state == IDLE ? (mem_op ? (dmem_gnt_i ? WAIT_RV : WAIT_GNT) : IDLE)
               : state == WAIT_GNT ? (dmem_gnt_i ? WAIT_RV : WAIT_GNT) : WAIT_RV;
   always_comb begin
      nxt_wb = '0;
      if (retire) begin
         nxt_wb.reg_write  = ex_i.reg_write & ~fault;
         nxt_wb.result_src = ex_i.result_src;
         nxt_wb.alu_result = ex_i.alu_result;
         nxt_wb.load_data  = (state == WAIT_RV && dmem_rvalid_i) ? load_data : '0;
         nxt_wb.imm_ext    = ex_i.imm_ext;
         nxt_wb.pc_plus4   = ex_i.pc_plus4;
         nxt_wb.rd         = ex_i.rd;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         wb_o       <= '0;
         wb_valid_o <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
      end else begin
         state      <= next;
         cnt        <= (state != IDLE && next == state) ? cnt + 1'b1 : '0;
         wb_o       <= nxt_wb;
         wb_valid_o <= retire;
         misalign_o <= (state == IDLE) & bad;
         bus_err_o  <= abort;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage against a spec-level model
module tb_mem_stage;
   import pipeline_pkg::*;
   localparam int TO = 4;
   logic        clk = 1'b0, rst_n = 1'b0;
   exmem_t      ex;
   memwb_t      wb;
   logic        ex_valid, stall, wb_valid, req, we, gnt, rvalid, mis, berr;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   int          errs = 0, checks = 0;
   logic        chk = 1'b0;
   logic        e_req, e_stall, e_we, e_wbv, e_rw, e_mis, e_berr, e_ldchk;
   logic [31:0] e_addr, e_wdata, e_ld;
   logic [3:0]  e_be;
   exmem_t      e_ex;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata;
   logic        cap_req;
   int          cap_stalls;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ex_i(ex), .ex_valid_i(ex_valid), .stall_o(stall),
      .wb_o(wb), .wb_valid_o(wb_valid), .dmem_req_o(req), .dmem_we_o(we),
      .dmem_addr_o(addr), .dmem_be_o(be), .dmem_wdata_o(wdata), .dmem_gnt_i(gnt),
      .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .misalign_o(mis), .bus_err_o(berr)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) if (chk) begin
      check("stall", stall, e_stall);
      check("req", req, e_req);
      if (e_req) begin
         check("we", we, e_we);
         check("addr", addr, e_addr);
         check("be", be, e_be);
         check("wdata", wdata, e_wdata);
      end
      check("wb_valid", wb_valid, e_wbv);
      check("reg_write", wb.reg_write, e_rw);
      check("misalign", mis, e_mis);
      check("bus_err", berr, e_berr);
      if (e_wbv) begin
         check("alu_result", wb.alu_result, e_ex.alu_result);
         check("result_src", wb.result_src, e_ex.result_src);
         check("imm_ext", wb.imm_ext, e_ex.imm_ext);
         check("pc_plus4", wb.pc_plus4, e_ex.pc_plus4);
         check("rd", wb.rd, e_ex.rd);
         if (e_ldchk) check("load_data", wb.load_data, e_ld);
      end
   end

   task automatic exp_bubble();
      e_wbv = 0; e_rw = 0; e_mis = 0; e_berr = 0; e_ldchk = 0;
   endtask

   // g: cycles gnt is withheld; rv: cycles from grant to rvalid (0 = never)
   task automatic run_op(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd2,
                         input int g, input int rv, input logic [31:0] rdv);
      logic ld, mem, legal, misal, bad, tmo;
      int sz, r, sh;
      logic [31:0] mask, v, wd;
      logic [3:0] bev;
      ld = !mw && rs == RESULT_LOAD;
      mem = ld || mw;
      sz = int'(f3[1:0]);
      legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
      misal = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
      bad = mem && (!legal || misal);
      tmo = ld && !bad && rv == 0;
      r = (!mem || bad) ? 0 : mw ? g : (rv > 0 ? g + rv : g + TO);
      sh = sz == 0 ? int'(a[1:0]) * 8 : sz == 1 ? int'(a[1]) * 16 : 0;
      mask = sz == 0 ? 32'hFF : sz == 1 ? 32'hFFFF : 32'hFFFF_FFFF;
      v = (rdv >> sh) & mask;
      if (!f3[2] && sz < 2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
      bev = sz == 0 ? 4'(1 << a[1:0]) : sz == 1 ? 4'(3 << (a[1] * 2)) : 4'hF;
      wd = sz == 0 ? (rd2 & 32'hFF) * 32'h0101_0101 : sz == 1 ? (rd2 & 32'hFFFF) * 32'h0001_0001 : rd2;
      ex = '{reg_write: !mw, result_src: rs, mem_write: mw, funct3: f3, alu_result: a,
             write_data: rd2, imm_ext: a ^ 32'h5A5A_0000, pc_plus4: a + 32'h1004, rd: 5'(a) ^ 5'd9};
      ex_valid = 1;
      cap_stalls = 0;
      for (int k = 0; k <= r; k++) begin
         gnt = mem && !bad && (k == g || (ld && k > g));
         rvalid = ld && !bad && (k < g || (k == r && rv > 0));
         rdata = (k == r) ? rdv : 32'hBAD0_0000 + 32'(k);
         e_req = mem && !bad && k <= g;
         e_stall = mem && k < r;
         e_we = mw; e_addr = a & ~32'h3; e_be = bev; e_wdata = wd;
         @(negedge clk);
         if (stall) cap_stalls++;
         if (k == 0) begin cap_be = be; cap_wdata = wdata; cap_req = req; end
         @(posedge clk); #1;
         if (k == r) begin
            e_wbv = 1; e_rw = !mw && !bad && !tmo; e_mis = bad; e_berr = tmo;
            e_ex = ex; e_ldchk = ld && !bad && !tmo; e_ld = v;
         end else exp_bubble();
      end
      gnt = 0; rvalid = 0; ex_valid = 0;
      e_req = 0; e_stall = 0;
   endtask

   task automatic idle(input int n);
      ex_valid = 0; gnt = 0; rvalid = 0; e_req = 0; e_stall = 0;
      repeat (n) begin
         @(negedge clk); @(posedge clk); #1;
         exp_bubble();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      ex = '0; ex_valid = 0; gnt = 0; rvalid = 0; rdata = 0;
      e_req = 0; e_stall = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_ld = 0; e_ex = '0;
      exp_bubble();
      repeat (2) @(posedge clk); #1;
      check("rst_req", req, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb", wb.alu_result | wb.load_data | 32'(wb.reg_write), 0);
      check("rst_flags", {mis, berr}, 0);
      #3 rst_n = 1;
      @(posedge clk); #1;
      chk = 1;
      run_op(1, 2'b00, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      check("sw_be", cap_be, 4'b1111);
      check("sw_wdata", cap_wdata, 32'hDEADBEEF);
      check("sw_stalls", cap_stalls, 0);
      check("sw_wb", {wb_valid, wb.reg_write}, 2'b10);
      run_op(1, 2'b00, F3_B, 32'h103, 32'h0000_00A5, 0, 0, 0);
      check("sb_be", cap_be, 4'b1000);
      check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      run_op(0, RESULT_LOAD, F3_B, 32'h102, 0, 0, 1, 32'h12F0_3456);
      check("lb_data", wb.load_data, 32'hFFFF_FFF0);
      check("lb_stalls", cap_stalls, 1);
      run_op(0, RESULT_LOAD, F3_BU, 32'h102, 0, 0, 1, 32'h12F0_3456);
      check("lbu_data", wb.load_data, 32'h0000_00F0);
      run_op(0, RESULT_LOAD, F3_W, 32'h102, 0, 0, 1, 0);
      check("lw_mis_req", cap_req, 0);
      check("lw_mis", {mis, wb_valid, wb.reg_write}, 3'b110);
      run_op(0, RESULT_LOAD, 3'b011, 32'h100, 0, 0, 1, 0);
      check("ld011", {cap_req, mis, wb_valid, wb.reg_write}, 4'b0110);
      run_op(0, RESULT_LOAD, F3_W, 32'h204, 0, 3, 1, 32'hCAFE_F00D);
      check("lw_gnt3_stalls", cap_stalls, 4);
      check("lw_gnt3_data", wb.load_data, 32'hCAFE_F00D);
      run_op(0, RESULT_LOAD, F3_H, 32'h102, 0, 0, 2, 32'h8001_0000);
      check("lh_data", wb.load_data, 32'hFFFF_8001);
      run_op(0, RESULT_LOAD, F3_HU, 32'h100, 0, 1, 3, 32'h1234_FFFE);
      run_op(1, 2'b00, F3_H, 32'h102, 32'h1234_ABCD, 2, 0, 0);
      check("sh_be", cap_be, 4'b1100);
      check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      run_op(0, 2'b00, 3'b000, 32'h0000_0040, 0, 0, 0, 0);
      run_op(1, 2'b00, 3'b011, 32'h100, 32'h1, 0, 0, 0);
      run_op(1, 2'b00, F3_H, 32'h101, 32'h1, 0, 0, 0);
      idle(1);
      run_op(0, RESULT_LOAD, F3_W, 32'h300, 0, 0, 0, 0);
      check("tmo_stalls", cap_stalls, TO);
      check("tmo_flags", {berr, wb_valid, wb.reg_write}, 3'b110);
      run_op(1, 2'b00, F3_W, 32'h304, 32'h0BAD_CAFE, 0, 0, 0);
      run_op(0, RESULT_LOAD, F3_W, 32'h106, 0, 0, 1, 0);
      chk = 0;
      rst_n = 0; #1;
      check("arst_clear", {wb_valid, mis, berr}, 0);
      check("arst_wb", wb.alu_result, 0);
      #1 rst_n = 1;
      exp_bubble();
      chk = 1;
      idle(1);
      chk = 0;
      ex = '{reg_write: 1, result_src: RESULT_LOAD, mem_write: 0, funct3: F3_W, alu_result: 32'h200,
             write_data: 0, imm_ext: 0, pc_plus4: 0, rd: 5'd3};
      ex_valid = 1; gnt = 0;
      @(posedge clk); #1;
      check("wgnt_req", req, 1);
      #1 rst_n = 0; #1;
      check("wgnt_rst_req", req, 0);
      check("wgnt_rst_out", {wb_valid, wb.reg_write, mis, berr}, 0);
      ex_valid = 0;
      #1 rst_n = 1;
      exp_bubble();
      chk = 1;
      run_op(1, 2'b00, F3_W, 32'h400, 32'h1357_9BDF, 0, 0, 0);
      check("post_rst_stalls", cap_stalls, 0);
      idle(2);
      chk = 0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the RV32I five-stage pipeline: consumes the EX/MEM bundle, performs loads and stores over a request/grant/rvalid data-memory bus, and registers the MEM/WB bundle. It stalls upstream stages while a bus access is outstanding and retires faulting accesses as bubbles.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles spent waiting for gnt or rvalid before the access is aborted.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_i  in  exmem_t  EX/MEM bundle; upstream holds it stable while stall_o=1.
- ex_valid_i  in  1  ex_i carries a real instruction.
- stall_o  out  1  freeze IF/ID/EX and the EX/MEM register this cycle.
- wb_o  out  memwb_t  registered MEM/WB bundle.
- wb_valid_o  out  1  wb_o holds a retired instruction.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word-aligned address, {ALUResult[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data word.
- misalign_o  out  1  one-cycle pulse: misaligned or illegal-funct3 access dropped.
- bus_err_o  out  1  one-cycle pulse: access aborted by timeout.

## Operation
- Load: ResultSrc==2'b01. Store: MemWrite==1. Anything else passes straight to MEM/WB in one cycle.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal. Store funct3: 000 SB, 001 SH, 010 SW; any other value is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Misaligned or illegal accesses issue no request. They retire with RegWrite=0 and wb_valid_o=1, and misalign_o pulses.
- Stores: SB drives wdata {4{RD2[7:0]}} with be 4'b0001<<addr[1:0]. SH drives {2{RD2[15:0]}} with be 4'b0011<<{addr[1],1'b0}. SW drives RD2 with be 4'b1111. The store data arrives in the WriteData field.
- Loads: select the byte or halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. The result goes to load_data.
- FSM states:
  - IDLE. A legal memory op with ex_valid_i drives dmem_req_o combinationally. With gnt, a store retires and a load goes to WAIT_RV. Without gnt, the FSM goes to WAIT_GNT.
  - WAIT_GNT. Hold req, addr, be, wdata and we. On gnt, a store retires to IDLE and a load goes to WAIT_RV.
  - WAIT_RV. req is low. On rvalid, capture the extracted data, retire, and return to IDLE.
- stall_o=1 whenever a memory op is present and does not retire in the current cycle.
- Timeout: a counter clears on entry to WAIT_GNT or WAIT_RV. When it reaches TIMEOUT_CYCLES, the access is dropped and retires with RegWrite=0 and wb_valid_o=1, bus_err_o pulses, and the FSM returns to IDLE.
- rvalid in IDLE or WAIT_GNT is ignored. gnt in WAIT_RV is ignored.
- Cycles with no retirement load a bubble: wb_valid_o=0 and RegWrite=0.
- The fields RegWrite, ResultSrc, ALUResult, ImmExt, PCPlus4 and Rd are copied from ex_i at retirement.

## Timing
- Reset is asynchronous. The FSM returns to IDLE, the counter clears, and every wb_o field, wb_valid_o, misalign_o and bus_err_o go to 0. dmem_req_o drops immediately, and an access in flight is abandoned.
- Non-memory op and same-cycle-gnt store: wb_o is valid on the next edge, with zero stall cycles.
- Load with same-cycle gnt and rvalid one cycle later: one stall cycle, and wb_o is valid two edges after entry.
- Each cycle of gnt delay adds one stall cycle. Each cycle of rvalid delay beyond the first also adds one stall cycle.
- misalign_o and bus_err_o are registered and coincide with the bubble retirement edge.
- A new memory op may issue in the IDLE cycle right after a retirement, so back-to-back accesses are supported.

## Structure
- Package pipeline_pkg gains:
  - mem_state_t enum {IDLE, WAIT_GNT, WAIT_RV};
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - RESULT_LOAD = 2'b01.
- Sub-module lsu_align, purely combinational, provides store lane and byte-enable generation, load extraction and extension, and misalign/illegal detection.
- mem_stage holds the FSM, the timeout counter and the MEM/WB register.

## Test plan
- SW RD2=0xDEADBEEF, addr 0x100, gnt same cycle: be=1111, wdata=0xDEADBEEF, no stall, wb_valid_o next edge with RegWrite=0.
- SB RD2=0x000000A5, addr 0x103: be=1000, wdata=0xA5A5A5A5.
- LB, addr 0x102, rdata 0x12F0_3456, gnt same cycle, rvalid +1: one stall cycle, load_data=0xFFFFFFF0. The same sequence with LBU gives 0x000000F0.
- LW, addr 0x102: no dmem_req_o, misalign_o pulses, RegWrite=0. funct3=011 on a load gives the same response.
- LW with gnt withheld for 3 cycles: stall_o is high 4 cycles, addr and be stay stable throughout, and load_data equals rdata.
- TIMEOUT_CYCLES=4 with rvalid never arriving: bus_err_o pulses after 4 WAIT_RV cycles, and the FSM returns to IDLE. Asserting rst_n low mid-WAIT_GNT drops req immediately and clears all outputs.
